// File: rtl/load_store_request_queue_if.sv
// Bundle of core request/response, cache port and status signals around the load/store queue.
// The queue side uses the slave modport; the environment (core + cache subsystem) uses master.
interface load_store_request_queue_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int PTR_WIDTH  = 2
);
    // Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
    // The sender keeps valid and payload steady until that edge; ready never depends on a
    // future valid. The cache port has no ready: the request is held while cache_stall=1.
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_we;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  req_flush;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_rdata;

    logic [ADDR_WIDTH-1:0] cache_addr;
    logic                  cache_read;
    logic                  cache_write;
    logic [DATA_WIDTH-1:0] cache_wdata;
    logic                  cache_flush;
    logic                  cache_stall;
    logic [DATA_WIDTH-1:0] cache_rdata;

    logic [PTR_WIDTH:0]    queue_count;
    logic                  busy;
    logic                  fsm_state;

    modport slave (
        input  req_valid, req_addr, req_we, req_wdata, req_flush,
        input  resp_ready, cache_stall, cache_rdata,
        output req_ready, resp_valid, resp_rdata,
        output cache_addr, cache_read, cache_write, cache_wdata, cache_flush,
        output queue_count, busy, fsm_state
    );

    modport master (
        output req_valid, req_addr, req_we, req_wdata, req_flush,
        output resp_ready, cache_stall, cache_rdata,
        input  req_ready, resp_valid, resp_rdata,
        input  cache_addr, cache_read, cache_write, cache_wdata, cache_flush,
        input  queue_count, busy, fsm_state
    );
endinterface

// File: rtl/load_store_request_queue.sv
// Load/store/flush request FIFO feeding the cache port one request at a time,
// with a single-entry load response register towards the core.
module load_store_request_queue #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int PTR_WIDTH  = 2
) (
    input logic clk,
    input logic rst,
    load_store_request_queue_if.slave bus
);
    localparam logic IDLE  = 1'b0;
    localparam logic ISSUE = 1'b1;

    localparam logic [PTR_WIDTH:0]   FULL_COUNT = (PTR_WIDTH + 1)'(DEPTH);
    localparam logic [PTR_WIDTH:0]   COUNT_ONE  = (PTR_WIDTH + 1)'(1);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE    = PTR_WIDTH'(1);

    logic [DEPTH-1:0]      fifo_flush;
    logic [DEPTH-1:0]      fifo_we;
    logic [ADDR_WIDTH-1:0] fifo_addr  [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_wdata [DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [PTR_WIDTH:0]    count;

    logic                  state;
    logic                  iss_read;
    logic                  iss_write;
    logic                  iss_flush;
    logic [ADDR_WIDTH-1:0] iss_addr;
    logic [DATA_WIDTH-1:0] iss_wdata;

    logic                  resp_valid_q;
    logic [DATA_WIDTH-1:0] resp_rdata_q;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic complete;
    logic head_is_load;
    logic slot_free;
    logic head_issuable;

    always_comb begin
        full         = (count == FULL_COUNT);
        empty        = (count == '0);
        push         = bus.req_valid && !full;
        complete     = (state == ISSUE) && !bus.cache_stall;
        head_is_load = !fifo_flush[rd_ptr] && !fifo_we[rd_ptr];
        // A load completing this edge fills the slot, so the next load must wait for it.
        slot_free     = (!resp_valid_q || bus.resp_ready) && !(complete && iss_read);
        head_issuable = !empty && (!head_is_load || slot_free);
        pop           = head_issuable && ((state == IDLE) || complete);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_flush[wr_ptr] <= bus.req_flush;
            fifo_we[wr_ptr]    <= bus.req_we && !bus.req_flush;
            fifo_addr[wr_ptr]  <= bus.req_addr;
            fifo_wdata[wr_ptr] <= bus.req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            iss_read  <= 1'b0;
            iss_write <= 1'b0;
            iss_flush <= 1'b0;
            iss_addr  <= '0;
            iss_wdata <= '0;
        end else if (pop) begin
            state     <= ISSUE;
            iss_read  <= head_is_load;
            iss_write <= fifo_we[rd_ptr];
            iss_flush <= fifo_flush[rd_ptr];
            iss_addr  <= fifo_addr[rd_ptr];
            iss_wdata <= fifo_wdata[rd_ptr];
        end else if (complete) begin
            state     <= IDLE;
            iss_read  <= 1'b0;
            iss_write <= 1'b0;
            iss_flush <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
        end else if (complete && iss_read) begin
            resp_valid_q <= 1'b1;
            resp_rdata_q <= bus.cache_rdata;
        end else if (resp_valid_q && bus.resp_ready) begin
            resp_valid_q <= 1'b0;
        end
    end

    assign bus.req_ready   = !full;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_rdata  = resp_rdata_q;
    assign bus.cache_addr  = iss_addr;
    assign bus.cache_read  = iss_read;
    assign bus.cache_write = iss_write;
    assign bus.cache_wdata = iss_wdata;
    assign bus.cache_flush = iss_flush;
    assign bus.queue_count = count;
    assign bus.busy        = !empty || (state == ISSUE);
    assign bus.fsm_state   = state;
endmodule

// File: tb/tb_load_store_request_queue.sv
// Bench for load_store_request_queue: directed scenarios then random traffic, checked by a
// negedge monitor against an in-order request queue, a response queue and a reference memory.
module tb_load_store_request_queue;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int PW    = 2;

    logic clk;
    logic rst;

    load_store_request_queue_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PTR_WIDTH(PW)) bus ();

    load_store_request_queue #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .PTR_WIDTH(PW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected cache operation: {read, write, flush, addr, wdata}
    logic [66:0] exp_q[$];
    logic [31:0] resp_q[$];
    logic [31:0] ref_mem   [8];
    logic [31:0] cache_mem [8];

    int compared   = 0;
    int mismatched = 0;
    int stall_mode = 2;   // 0 random, 1 stall, 2 no stall
    int rr_mode    = 1;   // 0 never ready, 1 always, 2 random

    task automatic check(string name, logic [66:0] act, logic [66:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(string name);
        compared++;
        mismatched++;
        $display("FAIL %s: got event expected none at %0t", name, $time);
    endtask

    function automatic logic [2:0] idx(logic [31:0] a);
        return a[4:2];
    endfunction

    function automatic logic [66:0] op_mask(logic [66:0] e);
        logic [66:0] m;
        m = {3'b111, 64'h0};
        if (!e[64]) m[63:32] = 32'hFFFF_FFFF;
        if (e[65])  m[31:0]  = 32'hFFFF_FFFF;
        return m;
    endfunction

    // ---------------- driver ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
        case (stall_mode)
            1:       bus.cache_stall = 1'b1;
            2:       bus.cache_stall = 1'b0;
            default: bus.cache_stall = ($urandom_range(0, 9) < 4);
        endcase
        case (rr_mode)
            0:       bus.resp_ready = 1'b0;
            1:       bus.resp_ready = 1'b1;
            default: bus.resp_ready = ($urandom_range(0, 9) < 6);
        endcase
        bus.cache_rdata = cache_mem[idx(bus.cache_addr)];
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic send(logic we, logic fl, logic [31:0] a, logic [31:0] d);
        logic acc;
        int   n;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_flush = fl;
        bus.req_addr  = a;
        bus.req_wdata = d;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = bus.req_ready;
            cycle();
            n++;
        end
        bus.req_valid = 1'b0;
        if (!acc) fail("send_timeout");
    endtask

    function automatic logic [31:0] rnd_addr();
        return 32'h0000_1000 + 32'(4 * $urandom_range(0, 7));
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic        chk_reset     = 1'b0;
    logic        prev_strobe   = 1'b0;
    logic        prev_complete = 1'b0;
    logic        exp_issue     = 1'b0;
    logic        model_slot    = 1'b0;
    logic [66:0] prev_act      = '0;
    logic [66:0] m_act;
    logic [66:0] m_exp;
    logic [66:0] m_msk;
    logic        m_strobe;
    logic        m_new;
    logic        m_complete;
    logic        m_pop;
    logic        m_accept;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            resp_q.delete();
            ref_mem       = cache_mem;
            chk_reset     = 1'b1;
            prev_strobe   = 1'b0;
            prev_complete = 1'b0;
            exp_issue     = 1'b0;
            model_slot    = 1'b0;
        end else begin
            m_act    = {bus.cache_read, bus.cache_write, bus.cache_flush, bus.cache_addr, bus.cache_wdata};
            m_strobe = bus.cache_read | bus.cache_write | bus.cache_flush;
            if (chk_reset) begin
                check("reset_cache_outputs", m_act, 67'h0);
                check("reset_resp_rdata", bus.resp_rdata, 0);
                chk_reset = 1'b0;
            end
            check("strobe_onehot", 1'((int'(bus.cache_read) + int'(bus.cache_write) + int'(bus.cache_flush)) <= 1), 1);

            m_new = m_strobe && (!prev_strobe || prev_complete);
            check("issue_timing", m_new, exp_issue);
            if (m_new) begin
                if (exp_q.size() == 0) begin
                    fail("issue_unexpected");
                end else begin
                    m_exp = exp_q.pop_front();
                    m_msk = op_mask(m_exp);
                    check("issue_op", m_act & m_msk, m_exp & m_msk);
                end
            end else if (prev_strobe && !prev_complete) begin
                check("hold_stable", m_act, prev_act);
            end

            check("queue_count", bus.queue_count, exp_q.size());
            check("req_ready", bus.req_ready, exp_q.size() != DEPTH);
            check("busy", bus.busy, (exp_q.size() != 0) || m_strobe);
            check("resp_valid", bus.resp_valid, model_slot);

            if (model_slot && bus.resp_ready) begin
                if (resp_q.size() == 0) fail("resp_unexpected");
                else check("resp_rdata", bus.resp_rdata, resp_q.pop_front());
            end

            m_complete = m_strobe && !bus.cache_stall;
            if (m_complete && bus.cache_write) cache_mem[idx(bus.cache_addr)] = bus.cache_wdata;

            m_pop = (exp_q.size() != 0) && (!m_strobe || m_complete);
            if (m_pop && exp_q[0][66])
                m_pop = (!model_slot || bus.resp_ready) && !(m_complete && bus.cache_read);

            if (m_complete && bus.cache_read) model_slot = 1'b1;
            else if (model_slot && bus.resp_ready) model_slot = 1'b0;

            m_accept = bus.req_valid && (exp_q.size() != DEPTH);
            if (m_accept) begin
                if (bus.req_flush) begin
                    exp_q.push_back({3'b001, bus.req_addr, bus.req_wdata});
                end else if (bus.req_we) begin
                    exp_q.push_back({3'b010, bus.req_addr, bus.req_wdata});
                    ref_mem[idx(bus.req_addr)] = bus.req_wdata;
                end else begin
                    exp_q.push_back({3'b100, bus.req_addr, bus.req_wdata});
                    resp_q.push_back(ref_mem[idx(bus.req_addr)]);
                end
            end

            prev_act      = m_act;
            prev_strobe   = m_strobe;
            prev_complete = m_complete;
            exp_issue     = m_pop;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int r;
        int n;
        for (int i = 0; i < 8; i++) begin
            cache_mem[i] = 32'hC0DE_0000 + 32'(i);
            ref_mem[i]   = 32'hC0DE_0000 + 32'(i);
        end
        rst             = 1'b1;
        bus.req_valid   = 1'b0;
        bus.req_we      = 1'b0;
        bus.req_flush   = 1'b0;
        bus.req_addr    = '0;
        bus.req_wdata   = '0;
        bus.resp_ready  = 1'b1;
        bus.cache_stall = 1'b0;
        bus.cache_rdata = '0;
        idle(3);
        rst = 1'b0;
        idle(2);

        // single store, then a load stalled for four cycles
        send(1'b1, 1'b0, 32'h0000_1010, 32'hDEAD_BEEF);
        idle(4);
        stall_mode = 1;
        send(1'b0, 1'b0, 32'h0000_1010, 32'h0);
        idle(4);
        stall_mode = 2;
        idle(4);

        // fill the queue behind a stalled store
        stall_mode = 1;
        for (int i = 0; i < 5; i++) send(1'b1, 1'b0, rnd_addr(), $urandom);
        @(negedge clk);
        check("full_queue_count", bus.queue_count, DEPTH);
        check("full_req_ready", bus.req_ready, 0);
        cycle();
        stall_mode = 2;
        send(1'b1, 1'b0, rnd_addr(), $urandom);
        idle(10);

        // two loads with the response slot held
        rr_mode = 0;
        send(1'b0, 1'b0, 32'h0000_1010, 32'h0);
        send(1'b0, 1'b0, 32'h0000_1014, 32'h0);
        idle(8);
        @(negedge clk);
        check("blocked_load_read", bus.cache_read, 0);
        check("blocked_load_resp_valid", bus.resp_valid, 1);
        cycle();
        rr_mode = 1;
        idle(8);

        // flush with we set
        send(1'b1, 1'b1, rnd_addr(), $urandom);
        idle(4);

        // reset in the middle of a stalled transaction
        stall_mode = 1;
        for (int i = 0; i < 3; i++) send(1'b1, 1'b0, rnd_addr(), $urandom);
        idle(2);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        stall_mode = 0;
        idle(2);

        // random traffic
        rr_mode = 2;
        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 9);
            send(r < 4, r >= 8, rnd_addr(), $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end

        // drain
        stall_mode = 2;
        rr_mode    = 1;
        n = 0;
        while ((bus.busy || bus.resp_valid) && n < 300) begin
            cycle();
            n++;
        end
        if (n >= 300) fail("drain_timeout");
        idle(3);
        check("drain_requests_left", exp_q.size(), 0);
        check("drain_responses_left", resp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/load_store_request_queue.md
Name: load_store_request_queue

Overview:
- Processor-side front end sitting directly upstream of the cache memory subsystem.
- Accepts load/store/flush requests from the core over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Issues one request at a time to the cache port (addr/read/write/wdata/flush), holding it until cache_stall drops.
- Returns load data to the core through a one-entry response register with its own valid/ready handshake.

Parameters:
- ADDR_WIDTH, 32, request address width (matches cache subsystem address).
- DATA_WIDTH, 32, word width.
- DEPTH, 4, request FIFO entries; must be a power of 2, >=2.
- PTR_WIDTH, 2, log2(DEPTH).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  core request present.
- req_ready  out  1  queue can accept; equals !full.
- req_addr  in  ADDR_WIDTH  byte address.
- req_we  in  1  1=store, 0=load.
- req_wdata  in  DATA_WIDTH  store data.
- req_flush  in  1  flush request; overrides req_we; addr/wdata ignored.
- resp_valid  out  1  load data available.
- resp_ready  in  1  core consumes response.
- resp_rdata  out  DATA_WIDTH  load data.
- cache_addr  out  ADDR_WIDTH  to subsystem addr.
- cache_read  out  1  to subsystem read.
- cache_write  out  1  to subsystem write.
- cache_wdata  out  DATA_WIDTH  to subsystem wdata.
- cache_flush  out  1  to subsystem flush.
- cache_stall  in  1  from subsystem stall; valid combinationally in the same cycle as the request.
- cache_rdata  in  DATA_WIDTH  from subsystem rdata.
- queue_count  out  PTR_WIDTH+1  FIFO occupancy.
- busy  out  1  FIFO non-empty or request in flight.

Behaviour:
- Reset (rst=1 at edge): FIFO pointers/count=0, state IDLE, in-flight request dropped, resp_valid=0, resp_rdata=0, cache_read/write/flush=0, cache_addr/wdata=0, req_ready=1, busy=0. Reset mid-transaction discards everything; the subsystem shares rst.
- Push: on edge with req_valid&&req_ready, store {flush, we&&!flush, addr, wdata} at write pointer. No pass-through when full: req_ready=0 at count==DEPTH even if a pop happens that cycle. Pointers wrap modulo DEPTH.
- FSM has two states, IDLE and ISSUE:
  - IDLE: all cache_* strobes 0. Move to ISSUE when the FIFO is non-empty and the head is issuable; pop the head into the issue register (registered outputs, 1-cycle issue latency).
  - ISSUE: drive exactly one of cache_read/cache_write/cache_flush from the issue register, plus cache_addr/cache_wdata. Hold all of them stable while cache_stall=1.
  - Completion is an edge in ISSUE with cache_stall=0. For a load, capture cache_rdata into resp_rdata and set resp_valid=1. Stores and flushes produce no response.
  - At completion, if the next head is issuable, pop it and remain in ISSUE (back-to-back, zero bubble). Otherwise go to IDLE.
- Issuable: stores/flushes always. Loads only if the response slot is free: resp_valid=0, or resp_ready=1 in the same cycle.
- Response: resp_valid clears on edge with resp_valid&&resp_ready unless a new load completes that edge, in which case it stays 1 with new data. A load is never issued while it could complete into an occupied slot.
- Ordering is strictly FIFO; a blocked load at the head blocks younger stores.
- Simultaneous push and pop: count unchanged, both pointers advance.
- queue_count counts FIFO entries only (excludes in-flight). busy = (queue_count!=0) || state==ISSUE.

Test Plan:
- Reset -> req_ready=1, resp_valid=0, cache strobes 0, queue_count=0, busy=0.
- Store 0x0000_1010←0xDEAD_BEEF with cache_stall=0 -> cache_write=1 for exactly 1 cycle, cache_addr=0x0000_1010, cache_wdata=0xDEADBEEF, no resp_valid.
- Load 0x0000_1010, cache_stall=1 for 4 cycles then 0, cache_rdata=0xDEADBEEF -> cache_read held 5 cycles with stable addr; resp_valid=1, resp_rdata=0xDEADBEEF the next cycle.
- Push 5 requests with cache_stall=1 -> req_ready=0 after the 4th queued (queue_count=4, 1 extra in flight); 5th accepted only after a pop.
- Two loads back-to-back, resp_ready=0 -> second load not issued (cache_read=0) until resp_ready=1; both data returned in order.
- Flush request with req_we=1 -> cache_flush=1, cache_write=0. rst asserted mid-stall -> all outputs return to reset values next cycle.
